// File: rtl/meas_seq.sv
// Ring-oscillator PUF measurement sequencer: fetches select pairs,
// gates the counters, votes on each comparison and shifts out the ID.
module meas_seq #(
    parameter int C_IOSCNUM      = 48,
    parameter int C_IOSCDWIDTH   = 24,
    parameter int C_OIDWIDTH     = 24,
    parameter int C_MEMDATAWIDTH = 8,
    parameter int C_MEMADDRWIDTH = 24,
    parameter int C_MEMLAT       = 1,
    parameter int C_WINDOW       = 16,
    parameter int C_SETTLE       = 2,
    parameter int C_VOTES        = 3
) (
    input  logic                              I_sclk,
    input  logic                              I_osc_rst,
    input  logic                              I_start,
    input  logic [C_MEMADDRWIDTH-1:0]         I_mem_base,
    input  logic [C_MEMDATAWIDTH-1:0]         I_mem_data,
    input  logic [C_IOSCNUM*C_IOSCDWIDTH-1:0] I_osc_data,
    output logic [C_MEMADDRWIDTH-1:0]         O_mem_addr,
    output logic                              O_osc_clr,
    output logic                              O_osc_en,
    output logic                              O_busy,
    output logic                              O_done,
    output logic [C_OIDWIDTH-1:0]             O_prim_id,
    output logic [C_OIDWIDTH-1:0]             O_unstable,
    output logic                              O_sel_err
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH1  = 4'd1;
    localparam logic [3:0] S_FETCH2  = 4'd2;
    localparam logic [3:0] S_CLEAR   = 4'd3;
    localparam logic [3:0] S_WINDOW  = 4'd4;
    localparam logic [3:0] S_SETTLE  = 4'd5;
    localparam logic [3:0] S_COMPARE = 4'd6;
    localparam logic [3:0] S_RESOLVE = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    localparam int CW = 16;
    localparam int VW = $clog2(C_VOTES + 1);
    localparam int BW = $clog2(C_OIDWIDTH + 1);

    logic [3:0]                state;
    logic [CW-1:0]             cnt;
    logic [VW-1:0]             vote_cnt;
    logic [VW-1:0]             ones;
    logic                      tie;
    logic [BW-1:0]             bit_cnt;
    logic [C_MEMDATAWIDTH-1:0] sel1;
    logic [C_MEMDATAWIDTH-1:0] sel2;

    logic [C_IOSCDWIDTH-1:0] cnt_a;
    logic [C_IOSCDWIDTH-1:0] cnt_b;
    logic                    bad_sel;
    logic                    vote;
    logic                    vbit;
    logic                    vunst;

    // Mux by search so out-of-range selects read as zero instead of
    // indexing past the packed count bus.
    always_comb begin
        cnt_a = '0;
        cnt_b = '0;
        for (int i = 0; i < C_IOSCNUM; i++) begin
            if (sel1 == C_MEMDATAWIDTH'(i))
                cnt_a = I_osc_data[i*C_IOSCDWIDTH +: C_IOSCDWIDTH];
            if (sel2 == C_MEMDATAWIDTH'(i))
                cnt_b = I_osc_data[i*C_IOSCDWIDTH +: C_IOSCDWIDTH];
        end
    end

    assign bad_sel = (int'(sel1) >= C_IOSCNUM)
                  || (int'(sel2) >= C_IOSCNUM)
                  || (sel1 == sel2);
    assign vote    = cnt_a > cnt_b;
    assign vbit    = !bad_sel && (ones > VW'(C_VOTES / 2));
    assign vunst   = bad_sel || tie
                  || !((ones == '0) || (ones == VW'(C_VOTES)));

    always_ff @(posedge I_sclk) begin
        if (!I_osc_rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            vote_cnt   <= '0;
            ones       <= '0;
            tie        <= 1'b0;
            bit_cnt    <= '0;
            sel1       <= '0;
            sel2       <= '0;
            O_mem_addr <= '0;
            O_osc_clr  <= 1'b0;
            O_osc_en   <= 1'b0;
            O_busy     <= 1'b0;
            O_done     <= 1'b0;
            O_prim_id  <= '0;
            O_unstable <= '0;
            O_sel_err  <= 1'b0;
        end else begin
            O_osc_clr <= 1'b0;
            O_done    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (I_start) begin
                        state      <= S_FETCH1;
                        O_busy     <= 1'b1;
                        O_mem_addr <= I_mem_base;
                        O_prim_id  <= '0;
                        O_unstable <= '0;
                        O_sel_err  <= 1'b0;
                        bit_cnt    <= '0;
                        vote_cnt   <= '0;
                        ones       <= '0;
                        tie        <= 1'b0;
                        cnt        <= '0;
                    end
                end
                S_FETCH1: begin
                    if (cnt == CW'(C_MEMLAT - 1)) begin
                        cnt        <= '0;
                        sel1       <= I_mem_data;
                        O_mem_addr <= O_mem_addr + 1'b1;
                        state      <= S_FETCH2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FETCH2: begin
                    if (cnt == CW'(C_MEMLAT - 1)) begin
                        cnt        <= '0;
                        sel2       <= I_mem_data;
                        O_mem_addr <= O_mem_addr + 1'b1;
                        O_osc_clr  <= 1'b1;
                        state      <= S_CLEAR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CLEAR: begin
                    O_osc_en <= 1'b1;
                    state    <= S_WINDOW;
                end
                S_WINDOW: begin
                    if (cnt == CW'(C_WINDOW - 1)) begin
                        cnt      <= '0;
                        O_osc_en <= 1'b0;
                        state    <= S_SETTLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CW'(C_SETTLE - 1)) begin
                        cnt   <= '0;
                        state <= S_COMPARE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_COMPARE: begin
                    vote_cnt <= vote_cnt + 1'b1;
                    ones     <= ones + VW'(vote);
                    tie      <= tie | (cnt_a == cnt_b);
                    if (vote_cnt == VW'(C_VOTES - 1)) begin
                        state <= S_RESOLVE;
                    end else begin
                        O_osc_clr <= 1'b1;
                        state     <= S_CLEAR;
                    end
                end
                S_RESOLVE: begin
                    O_prim_id  <= {O_prim_id[C_OIDWIDTH-2:0], vbit};
                    O_unstable <= {O_unstable[C_OIDWIDTH-2:0], vunst};
                    O_sel_err  <= O_sel_err | bad_sel;
                    vote_cnt   <= '0;
                    ones       <= '0;
                    tie        <= 1'b0;
                    bit_cnt    <= bit_cnt + 1'b1;
                    if (bit_cnt == BW'(C_OIDWIDTH - 1))
                        state <= S_DONE;
                    else
                        state <= S_FETCH1;
                end
                S_DONE: begin
                    O_done <= 1'b1;
                    O_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_meas_seq.sv
// Scoreboard bench for meas_seq: directed runs queue their expected
// ID/mask/error/address/latency, a monitor checks them on O_done.
module tb_meas_seq;

    localparam int N  = 48;
    localparam int W  = 24;
    localparam int ID = 24;
    localparam int T_DONE = 1513;

    logic             I_sclk = 1'b0;
    logic             I_osc_rst = 1'b0;
    logic             I_start = 1'b0;
    logic [23:0]      I_mem_base = '0;
    logic [7:0]       I_mem_data;
    logic [N*W-1:0]   I_osc_data;
    logic [23:0]      O_mem_addr;
    logic             O_osc_clr;
    logic             O_osc_en;
    logic             O_busy;
    logic             O_done;
    logic [ID-1:0]    O_prim_id;
    logic [ID-1:0]    O_unstable;
    logic             O_sel_err;

    meas_seq dut (
        .I_sclk     (I_sclk),
        .I_osc_rst  (I_osc_rst),
        .I_start    (I_start),
        .I_mem_base (I_mem_base),
        .I_mem_data (I_mem_data),
        .I_osc_data (I_osc_data),
        .O_mem_addr (O_mem_addr),
        .O_osc_clr  (O_osc_clr),
        .O_osc_en   (O_osc_en),
        .O_busy     (O_busy),
        .O_done     (O_done),
        .O_prim_id  (O_prim_id),
        .O_unstable (O_unstable),
        .O_sel_err  (O_sel_err)
    );

    always #5 I_sclk = ~I_sclk;

    typedef struct {
        logic [23:0] prim;
        logic [23:0] unst;
        logic [23:0] addr;
        logic        err;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   clr_idx = 0;
    int   mode = 0;
    logic [7:0]  memv[48];
    logic [23:0] mem_off;

    always @(posedge I_sclk) cyc <= cyc + 1;

    // Measurement index follows the clear pulses of the current run.
    always @(posedge I_sclk) begin
        if (!I_osc_rst || (I_start && !O_busy)) clr_idx <= 0;
        else if (O_osc_clr) clr_idx <= clr_idx + 1;
    end

    always_comb begin
        mem_off = O_mem_addr - I_mem_base;
        I_mem_data = 8'd0;
        if (mem_off < 24'd48) I_mem_data = memv[mem_off[5:0]];
    end

    int m_i, b_i, v_i;
    logic [W-1:0] c0, c1;
    always_comb begin
        m_i = (clr_idx > 0) ? clr_idx - 1 : 0;
        b_i = m_i / 3;
        v_i = m_i % 3;
        c0 = 24'd100;
        c1 = 24'd50;
        if (mode == 2) begin
            if (b_i == 23 && v_i == 1) begin
                c0 = 24'd50;
                c1 = 24'd100;
            end
            if (b_i == 0) begin
                c0 = 24'd70;
                c1 = 24'd70;
            end
        end
        I_osc_data = '0;
        I_osc_data[0*W +: W] = c0;
        I_osc_data[1*W +: W] = c1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge I_sclk);
            #1;
            if (O_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(O_done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("prim_id", 32'(O_prim_id), 32'(e.prim));
                    chk("unstable", 32'(O_unstable), 32'(e.unst));
                    chk("sel_err", 32'(O_sel_err), 32'(e.err));
                    chk("mem_addr", 32'(O_mem_addr), 32'(e.addr));
                    chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    chk("busy_at_done", 32'(O_busy), 32'd0);
                end
            end
        end
    end

    task automatic set_pat(input bit alt);
        for (int k = 0; k < 24; k++) begin
            if (alt && k[0]) begin
                memv[2*k]   = 8'd1;
                memv[2*k+1] = 8'd0;
            end else begin
                memv[2*k]   = 8'd0;
                memv[2*k+1] = 8'd1;
            end
        end
    endtask

    task automatic run(input logic [23:0] base, input int md,
                       input logic [23:0] prim, input logic [23:0] unst,
                       input logic err, input bit restart);
        exp_t e;
        @(negedge I_sclk);
        I_mem_base = base;
        mode = md;
        I_start = 1'b1;
        @(posedge I_sclk);
        #1;
        e.prim = prim;
        e.unst = unst;
        e.err = err;
        e.addr = base + 24'd48;
        e.done_cyc = cyc + T_DONE;
        sb.push_back(e);
        @(negedge I_sclk);
        I_start = 1'b0;
        if (restart) begin
            repeat (100) @(negedge I_sclk);
            I_start = 1'b1;
            @(negedge I_sclk);
            I_start = 1'b0;
        end
        for (int i = 0; i < 2000 && sb.size() != 0; i++)
            @(posedge I_sclk);
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (3) @(negedge I_sclk);
    endtask

    initial begin
        set_pat(1'b0);
        repeat (3) @(posedge I_sclk);
        #1;
        chk("rst_busy", 32'(O_busy), 32'd0);
        chk("rst_en", 32'(O_osc_en), 32'd0);
        chk("rst_clr", 32'(O_osc_clr), 32'd0);
        chk("rst_done", 32'(O_done), 32'd0);
        chk("rst_addr", 32'(O_mem_addr), 32'd0);
        chk("rst_prim", 32'(O_prim_id), 32'd0);
        chk("rst_err", 32'(O_sel_err), 32'd0);
        @(negedge I_sclk);
        I_osc_rst = 1'b1;

        run(24'd0, 0, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0);

        set_pat(1'b1);
        run(24'd0, 0, 24'hAAAAAA, 24'h000000, 1'b0, 1'b0);

        set_pat(1'b0);
        run(24'd0, 2, 24'h7FFFFF, 24'h800001, 1'b0, 1'b0);

        set_pat(1'b0);
        memv[0] = 8'd5;
        memv[1] = 8'd5;
        memv[47] = 8'd60;
        run(24'd0, 0, 24'h7FFFFE, 24'h800001, 1'b1, 1'b0);

        set_pat(1'b0);
        run(24'hFFFFFC, 0, 24'hFFFFFF, 24'h000000, 1'b0, 1'b1);

        @(negedge I_sclk);
        I_mem_base = 24'd0;
        mode = 0;
        I_start = 1'b1;
        @(negedge I_sclk);
        I_start = 1'b0;
        for (int i = 0; i < 100 && !O_osc_en; i++) @(negedge I_sclk);
        chk("window_seen", 32'(O_osc_en), 32'd1);
        repeat (3) @(negedge I_sclk);
        I_osc_rst = 1'b0;
        @(posedge I_sclk);
        #1;
        chk("midrst_en", 32'(O_osc_en), 32'd0);
        chk("midrst_busy", 32'(O_busy), 32'd0);
        chk("midrst_addr", 32'(O_mem_addr), 32'd0);
        chk("midrst_prim", 32'(O_prim_id), 32'd0);
        @(negedge I_sclk);
        I_osc_rst = 1'b1;
        run(24'd0, 0, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/meas_seq.md
Name: meas_seq

Overview:
- Next-generation PUF measurement sequencer for the ring-oscillator array.
- Per ID bit:
  - fetches two oscillator selects from challenge memory;
  - gates the external oscillator counters for a programmable window;
  - compares the two selected counts;
  - repeats for majority voting;
  - shifts the voted bit into the ID register.
- Adds a start/busy/done handshake, a memory-latency parameter, voting, a per-bit instability mask and select-error detection.
- Sits between challenge ROM/RAM, the meas_osc counter array and the ID consumer.

Parameters:
- C_IOSCNUM, 48: number of oscillator channels.
- C_IOSCDWIDTH, 24: count width per channel.
- C_OIDWIDTH, 24: ID bits produced per run.
- C_MEMDATAWIDTH, 8: select width (one select per memory word).
- C_MEMADDRWIDTH, 24: challenge memory address width.
- C_MEMLAT, 1: memory read latency in cycles, >=1.
- C_WINDOW, 16: counter enable window in cycles, >=1.
- C_SETTLE, 2: cycles after window before counts are compared, >=1; covers count synchronisation.
- C_VOTES, 3: measurements per bit, odd, >=1.

Ports:
- I_sclk, in, 1: clock.
- I_osc_rst, in, 1: synchronous active-low reset.
- I_start, in, 1: start pulse, honoured only in IDLE.
- I_mem_base, in, C_MEMADDRWIDTH: first challenge address, sampled with I_start.
- I_mem_data, in, C_MEMDATAWIDTH: challenge memory read data.
- I_osc_data, in, C_IOSCNUM*C_IOSCDWIDTH: packed counts, channel i at [i*C_IOSCDWIDTH +: C_IOSCDWIDTH], already in the I_sclk domain.
- O_mem_addr, out, C_MEMADDRWIDTH: challenge memory address.
- O_osc_clr, out, 1: counter clear, one cycle.
- O_osc_en, out, 1: counter enable.
- O_busy, out, 1: run in progress.
- O_done, out, 1: one-cycle pulse at end of run.
- O_prim_id, out, C_OIDWIDTH: ID shift register.
- O_unstable, out, C_OIDWIDTH: per-bit instability mask, aligned with O_prim_id.
- O_sel_err, out, 1: sticky select error for the current run.

Behaviour:
- Reset (I_osc_rst=0 at a clock edge), from any state including mid-run: state IDLE, all outputs 0, O_mem_addr=0, all internal counters 0.
- IDLE
  - I_start=1 -> FETCH1.
  - At that edge: O_busy=1, O_mem_addr=I_mem_base, O_prim_id=0, O_unstable=0, O_sel_err=0, bit and vote counters cleared.
- FETCH1
  - Lasts C_MEMLAT cycles.
  - On the last edge: sel1=I_mem_data and O_mem_addr+=1 (wraps modulo 2^C_MEMADDRWIDTH), then -> FETCH2.
- FETCH2: same as FETCH1 for sel2, then -> CLEAR.
- CLEAR: 1 cycle with O_osc_clr=1, then -> WINDOW.
- WINDOW: C_WINDOW cycles with O_osc_en=1, then -> SETTLE.
- SETTLE: C_SETTLE cycles, en=0, then -> COMPARE.
- COMPARE: 1 cycle.
  - Vote is 1 if count[sel1] > count[sel2], unsigned; equal counts vote 0 and mark a tie.
  - Accumulate the ones count.
  - If votes taken < C_VOTES -> CLEAR, else -> RESOLVE.
- RESOLVE: 1 cycle.
  - O_prim_id <= {O_prim_id[C_OIDWIDTH-2:0], bit}; O_unstable shifts the same way.
  - bit = ones > C_VOTES/2.
  - unstable = (votes not unanimous) or any tie.
  - Vote state is cleared.
  - If bits done < C_OIDWIDTH -> FETCH1, else -> DONE.
- DONE: O_done=1 for one cycle, O_busy=0, then -> IDLE. O_prim_id and O_unstable hold until the next start.
- Select error: sel >= C_IOSCNUM or sel1==sel2.
  - O_sel_err=1, sticky for the run.
  - That bit is forced to 0 and its unstable flag to 1.
  - The measurement sequence still runs, so timing is data-independent.
- Timing:
  - T_bit = 2*C_MEMLAT + C_VOTES*(C_WINDOW+C_SETTLE+2) + 1 cycles.
  - O_done rises C_OIDWIDTH*T_bit + 1 cycles after the start edge. With defaults, T_bit = 63 and O_done rises at cycle 1513.
- Handshake: I_start while O_busy=1 is ignored. I_start in the same cycle as DONE is ignored; start is accepted only in IDLE.
- Memory reads: exactly 2*C_OIDWIDTH reads per run. Final O_mem_addr = I_mem_base + 2*C_OIDWIDTH, modulo 2^C_MEMADDRWIDTH.

Test Plan:
1. Reset then start with base=0, memory pairs (0,1)x24, count0=100, count1=50 -> O_prim_id=24'hFFFFFF, O_unstable=0, O_sel_err=0, O_done exactly at cycle 1513, O_mem_addr=48.
2. Alternating memory pairs (0,1)/(1,0), same counts -> O_prim_id=24'hAAAAAA, since the first bit ends at the MSB.
3. Counts flip between votes (vote results 1,0,1 on bit 0, stable otherwise) -> bit0=1, O_unstable=24'h000001. Equal counts on one bit -> bit 0 with its unstable flag set.
4. Pair (5,5) or select 60 -> O_sel_err=1, forced bit 0, unstable 1, done timing unchanged.
5. Base=2^24-4 -> O_mem_addr wraps through 0 and ends at 44. Second I_start during busy -> ignored, same result.
6. Reset asserted mid-WINDOW -> next edge: O_osc_en=0, O_busy=0, outputs 0. New start then produces a full correct run.
